madd_err_eval: RTL and testbench

MADD_ERR_EVAL -- requirements
Module: madd_err_eval

---
 rtl/madd_eval_pkg.sv | 19 +
 rtl/madd_exact.sv | 28 ++
 rtl/madd_err_eval.sv | 190 +++++++++++++++++++
 tb/tb_madd_err_eval.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/madd_eval_pkg.sv
// rtl/madd_eval_pkg.sv - shared widths, vector count and FSM state type for the multiply-add error evaluator
package madd_eval_pkg;

    localparam int A_W_DEF = 6;
    localparam int B_W_DEF = 6;
    localparam int C_W_DEF = 6;
    localparam int O_W_DEF = 12;

    // Default sweep covers every {a, b, c} combination.
    localparam int VEC_W   = A_W_DEF + B_W_DEF + C_W_DEF;
    localparam int N_VEC   = 1 << VEC_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/madd_exact.sv
// rtl/madd_exact.sv - combinational exact reference y = a*b + c
//
// Ports:
//   a [A_W-1:0]  multiplicand
//   b [B_W-1:0]  multiplier
//   c [C_W-1:0]  addend
//   y [O_W-1:0]  exact result, zero-extended to O_W bits
module madd_exact
    import madd_eval_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int C_W = C_W_DEF,
    parameter int O_W = O_W_DEF
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [C_W-1:0] c,
    output logic [O_W-1:0] y
);

    // Operands widened to the full product width so no bits are lost.
    logic [A_W+B_W-1:0] prod;

    assign prod = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
    assign y    = O_W'(prod) + O_W'(c);

endmodule

// File: rtl/madd_err_eval.sv
// rtl/madd_err_eval.sv - exhaustive-sweep error evaluator for an approximate multiply-add
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    one-cycle request to begin a sweep (accepted only when idle)
//   abort    terminates a sweep in progress
//   dut_in   registered stimulus {a, b, c} to the circuit under test
//   dut_out  combinational result from the circuit under test
//   busy     high while a sweep or its drain is in progress
//   done     one-cycle pulse when the metrics are final
//   aborted  set with done when the sweep was aborted, held until next start
//   err_cnt  number of vectors with dut_out != exact
//   max_err  largest |dut_out - exact|
//   sum_err  sum of |dut_out - exact|
module madd_err_eval
    import madd_eval_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int C_W = C_W_DEF,
    parameter int O_W = O_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       abort,
    output logic [A_W+B_W+C_W-1:0]     dut_in,
    input  logic [O_W-1:0]             dut_out,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic [A_W+B_W+C_W:0]       err_cnt,
    output logic [O_W-1:0]             max_err,
    output logic [O_W+A_W+B_W+C_W-1:0] sum_err
);

    localparam int N_W = A_W + B_W + C_W;
    localparam int S_W = O_W + N_W;

    state_t         state;
    state_t         state_nxt;
    logic           drain_cnt;
    logic           abort_pend;

    logic           accept;
    logic           present;
    logic           last_vec;

    logic [O_W-1:0] exact;
    logic [O_W-1:0] abs_err;

    logic           s1_valid;
    logic [O_W-1:0] s1_err;

    assign last_vec = (dut_in == {N_W{1'b1}});

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)              state_nxt = ST_SWEEP;
            ST_SWEEP: if (last_vec || abort)  state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_cnt)          state_nxt = ST_IDLE;
            default:                          state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        accept  = 1'b0;
        present = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE:  accept = start;
            ST_SWEEP: begin
                present = 1'b1;
                busy    = 1'b1;
            end
            ST_DRAIN: begin
                busy    = 1'b1;
                done    = drain_cnt;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Vector counter and sweep bookkeeping
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in     <= '0;
            drain_cnt  <= 1'b0;
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            // The counter parks on the last presented vector, so an abort
            // leaves dut_in frozen on whatever was being evaluated.
            if (accept) begin
                dut_in <= '0;
            end else if (present && !last_vec && !abort) begin
                dut_in <= dut_in + 1'b1;
            end

            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;

            // An abort landing on the final vector is a completed sweep.
            if (accept) begin
                abort_pend <= 1'b0;
            end else if (present && abort && !last_vec) begin
                abort_pend <= 1'b1;
            end

            // aborted rises in the same cycle done pulses.
            if (accept) begin
                aborted <= 1'b0;
            end else if (state == ST_DRAIN && !drain_cnt) begin
                aborted <= abort_pend;
            end
        end
    end

    // ---------------------------------------------------------------
    // Stage 1: exact result and absolute error of the current vector
    // ---------------------------------------------------------------
    madd_exact #(
        .A_W (A_W),
        .B_W (B_W),
        .C_W (C_W),
        .O_W (O_W)
    ) u_exact (
        .a (dut_in[C_W+B_W +: A_W]),
        .b (dut_in[C_W +: B_W]),
        .c (dut_in[C_W-1:0]),
        .y (exact)
    );

    assign abs_err = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_err   <= '0;
        end else begin
            s1_valid <= present;
            s1_err   <= abs_err;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: accumulators, wide enough that none can wrap
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            max_err <= '0;
            sum_err <= '0;
        end else if (accept) begin
            err_cnt <= '0;
            max_err <= '0;
            sum_err <= '0;
        end else if (s1_valid) begin
            sum_err <= sum_err + S_W'(s1_err);
            if (s1_err != '0) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (s1_err > max_err) begin
                max_err <= s1_err;
            end
        end
    end

endmodule

// File: tb/tb_madd_err_eval.sv
// tb/tb_madd_err_eval.sv - self-checking bench for madd_err_eval with a reduced-width sweep
module tb_madd_err_eval;

    localparam int TA = 4;
    localparam int TB = 4;
    localparam int TC = 4;
    localparam int TO = 9;
    localparam int NW = TA + TB + TC;
    localparam int NV = 1 << NW;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [NW-1:0]     dut_in;
    logic [TO-1:0]     dut_out;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [NW:0]       err_cnt;
    logic [TO-1:0]     max_err;
    logic [TO+NW-1:0]  sum_err;

    logic [TO-1:0]     gold_y;
    logic [TO-1:0]     lut [0:NV-1];
    int                mode;

    int                checks;
    int                fails;

    madd_err_eval #(.A_W(TA), .B_W(TB), .C_W(TC), .O_W(TO)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .dut_in  (dut_in),
        .dut_out (dut_out),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .err_cnt (err_cnt),
        .max_err (max_err),
        .sum_err (sum_err)
    );

    madd_exact #(.A_W(TA), .B_W(TB), .C_W(TC), .O_W(TO)) u_gold (
        .a (dut_in[TC+TB +: TA]),
        .b (dut_in[TC +: TB]),
        .c (dut_in[TC-1:0]),
        .y (gold_y)
    );

    // Circuit under test: exact, stuck-at-0, stuck-at-all-ones, or a random table.
    assign dut_out = (mode == 0) ? gold_y :
                     (mode == 1) ? {TO{1'b0}} :
                     (mode == 2) ? {TO{1'b1}} : lut[dut_in];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exact_of(input int v);
        int a, b, c;
        a = (v >> (TB + TC)) % (1 << TA);
        b = (v >> TC) % (1 << TB);
        c = v % (1 << TC);
        return a * b + c;
    endfunction

    function automatic int out_of(input int m, input int v);
        case (m)
            0:       return exact_of(v);
            1:       return 0;
            2:       return (1 << TO) - 1;
            default: return int'(lut[v]);
        endcase
    endfunction

    task automatic model(input int m, input int nvec,
                         output int e, output int mx, output longint s);
        int d;
        e = 0; mx = 0; s = 0;
        for (int v = 0; v < nvec; v++) begin
            d = out_of(m, v) - exact_of(v);
            if (d < 0) d = -d;
            if (d != 0) e++;
            if (d > mx) mx = d;
            s += d;
        end
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input string name, input int m, input int abort_at, input bit poke);
        int     cnt, nvec, exp_e, exp_m;
        longint exp_s;
        bit     got_done;
        nvec = (abort_at >= 0 && abort_at < NV) ? abort_at : NV;
        model(m, nvec, exp_e, exp_m, exp_s);
        mode     = m;
        start    = 1'b1;
        cnt      = 0;
        got_done = 1'b0;
        while (!got_done && cnt < NV + 50) begin
            @(posedge clk);
            cnt++;
            #1;
            if (cnt == 1) check({name, " busy_start"}, longint'(busy), 1);
            start = poke && (cnt == 100);
            abort = (abort_at >= 0) && (cnt == abort_at);
            if (done) got_done = 1'b1;
        end
        start = 1'b0;
        abort = 1'b0;
        check({name, " done_cycle"}, cnt, nvec + 2);
        check({name, " aborted"}, longint'(aborted), (nvec < NV) ? 1 : 0);
        check({name, " err_cnt"}, longint'(err_cnt), exp_e);
        check({name, " max_err"}, longint'(max_err), exp_m);
        check({name, " sum_err"}, longint'(sum_err), exp_s);
        check({name, " dut_in_frozen"}, longint'(dut_in), nvec - 1);
        @(posedge clk);
        #1;
        check({name, " busy_end"}, longint'(busy), 0);
        check({name, " done_pulse"}, longint'(done), 0);
        repeat (5) @(posedge clk);
        #1;
        check({name, " err_cnt_hold"}, longint'(err_cnt), exp_e);
        check({name, " sum_err_hold"}, longint'(sum_err), exp_s);
    endtask

    initial begin
        bit saw_done;
        checks = 0;
        fails  = 0;
        mode   = 0;
        start  = 1'b0;
        abort  = 1'b0;
        rst_n  = 1'b0;
        for (int v = 0; v < NV; v++) begin
            if ($urandom_range(3) == 0) lut[v] = TO'($urandom_range((1 << TO) - 1));
            else                        lut[v] = TO'(exact_of(v));
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst dut_in", longint'(dut_in), 0);
        check("rst busy", longint'(busy), 0);
        check("rst done", longint'(done), 0);
        check("rst aborted", longint'(aborted), 0);
        check("rst err_cnt", longint'(err_cnt), 0);
        check("rst max_err", longint'(max_err), 0);
        check("rst sum_err", longint'(sum_err), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_sweep("exact", 0, -1, 1'b0);
        run_sweep("zero", 1, -1, 1'b0);
        run_sweep("ones", 2, -1, 1'b0);
        run_sweep("abort1000", 1, 1000, 1'b0);
        run_sweep("abort_last", 3, NV, 1'b0);
        run_sweep("start_ignored", 1, -1, 1'b1);

        // Reset in the middle of a sweep: everything clears at once, no done.
        mode  = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst dut_in", longint'(dut_in), 0);
        check("midrst busy", longint'(busy), 0);
        check("midrst done", longint'(done), 0);
        check("midrst aborted", longint'(aborted), 0);
        check("midrst err_cnt", longint'(err_cnt), 0);
        check("midrst max_err", longint'(max_err), 0);
        check("midrst sum_err", longint'(sum_err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("midrst no_activity", longint'(saw_done), 0);

        run_sweep("after_rst_rand", 3, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
